// File: rtl/sequencia_scheduler.sv
// -----------------------------------------------------------------------------
// sequencia_scheduler
//
// Round-robin scheduler that time-shares one 8-bit serial sequence detector
// between N_REQ requesters. For each granted requester it loads that
// requester's pattern into the detector (setar_palavra), issues start, then
// watches encontrado under a per-job bit-count limit. The job ends with a
// one-cycle done pulse to the owner, with hit=1 (found) or hit=0 (limit
// reached). On a miss the pattern is re-loaded once (CLEAR) to stop the
// detector's search before the job is released.
//
// Optional feature: define SEQ_SCHED_STATS_EN to add saturating 16-bit
// hit_count / miss_count outputs. With the macro undefined those ports and
// counters do not exist and the rest of the behaviour is unchanged.
//
// Parameters:
//   N_REQ    number of requesters (2..8)
//   LIMIT_W  width of limite and of the search counter
//
// Ports:
//   clk                in   system clock, rising edge
//   rst_n              in   asynchronous active-low reset
//   req                in   per-requester job request (level)
//   req_palavra        in   pattern of requester i in bits [8i+7:8i]
//   limite             in   max search cycles per job, 0 = no limit
//   grant              out  one-hot detector owner, 0 when idle
//   done               out  one-cycle job-end pulse to the owner
//   hit                out  valid with done: 1 found, 0 limit reached
//   busy               out  high in every state except IDLE
//   hit_count          out  (SEQ_SCHED_STATS_EN) saturating hit counter
//   miss_count         out  (SEQ_SCHED_STATS_EN) saturating miss counter
//   det_setar_palavra  out  detector setar_palavra
//   det_palavra        out  detector palavra
//   det_start          out  detector start
//   det_encontrado     in   detector encontrado
// -----------------------------------------------------------------------------
module sequencia_scheduler #(
  parameter int N_REQ   = 4,
  parameter int LIMIT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req,
  input  logic [8*N_REQ-1:0]   req_palavra,
  input  logic [LIMIT_W-1:0]   limite,
  output logic [N_REQ-1:0]     grant,
  output logic [N_REQ-1:0]     done,
  output logic [N_REQ-1:0]     hit,
  output logic                 busy,
`ifdef SEQ_SCHED_STATS_EN
  output logic [15:0]          hit_count,
  output logic [15:0]          miss_count,
`endif
  output logic                 det_setar_palavra,
  output logic [7:0]           det_palavra,
  output logic                 det_start,
  input  logic                 det_encontrado
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_START  = 3'd2,
    ST_SEARCH = 3'd3,
    ST_CLEAR  = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  state_t              state_r;
  logic [IDX_W-1:0]    rr_ptr_r;
  logic [IDX_W-1:0]    owner_r;
  logic [LIMIT_W-1:0]  cnt_r;

  logic                pick_found_s;
  logic [IDX_W-1:0]    pick_idx_s;
  logic [N_REQ-1:0]    pick_grant_s;
  logic [7:0]          pick_pal_s;
  logic [LIMIT_W:0]    cnt_plus1_s;
  logic                limit_reached_s;
  logic [IDX_W-1:0]    next_rr_s;

  // Round-robin pick: first set req bit scanning upward from rr_ptr_r with wrap.
  always_comb begin
    logic [IDX_W-1:0] cand;
    pick_found_s = 1'b0;
    pick_idx_s   = '0;
    cand         = rr_ptr_r;
    for (int k = 0; k < N_REQ; k++) begin
      if (!pick_found_s && req[cand]) begin
        pick_found_s = 1'b1;
        pick_idx_s   = cand;
      end else begin
        pick_found_s = pick_found_s;
      end
      if (cand == IDX_W'(N_REQ - 1)) begin
        cand = '0;
      end else begin
        cand = cand + IDX_W'(1);
      end
    end
  end

  // Decode the picked index into a one-hot grant and select its pattern.
  always_comb begin
    pick_grant_s = '0;
    pick_pal_s   = 8'h00;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_found_s && (pick_idx_s == IDX_W'(i))) begin
        pick_grant_s[i] = 1'b1;
        pick_pal_s      = req_palavra[8*i +: 8];
      end else begin
        pick_grant_s[i] = 1'b0;
      end
    end
  end

  // Limit check: one bit wider so a saturated counter can never match.
  always_comb begin
    cnt_plus1_s = {1'b0, cnt_r} + {{LIMIT_W{1'b0}}, 1'b1};
    if (limite != '0) begin
      limit_reached_s = (cnt_plus1_s == {1'b0, limite});
    end else begin
      limit_reached_s = 1'b0;
    end
  end

  // Pointer advances past the owner so it is served last next time round.
  always_comb begin
    if (owner_r == IDX_W'(N_REQ - 1)) begin
      next_rr_s = '0;
    end else begin
      next_rr_s = owner_r + IDX_W'(1);
    end
  end

  // Main scheduler FSM; every output is registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r           <= ST_IDLE;
      rr_ptr_r          <= '0;
      owner_r           <= '0;
      cnt_r             <= '0;
      grant             <= '0;
      done              <= '0;
      hit               <= '0;
      busy              <= 1'b0;
      det_setar_palavra <= 1'b0;
      det_palavra       <= 8'h00;
      det_start         <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pick_found_s) begin
            grant             <= pick_grant_s;
            owner_r           <= pick_idx_s;
            det_palavra       <= pick_pal_s;
            det_setar_palavra <= 1'b1;
            busy              <= 1'b1;
            state_r           <= ST_LOAD;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_LOAD: begin
          det_setar_palavra <= 1'b0;
          det_start         <= 1'b1;
          state_r           <= ST_START;
        end
        ST_START: begin
          det_start <= 1'b0;
          cnt_r     <= '0;
          state_r   <= ST_SEARCH;
        end
        ST_SEARCH: begin
          if (cnt_r != {LIMIT_W{1'b1}}) begin
            cnt_r <= cnt_r + LIMIT_W'(1);
          end else begin
            cnt_r <= cnt_r;
          end
          // Found wins over the limit when both land in the same cycle.
          if (det_encontrado) begin
            done    <= grant;
            hit     <= grant;
            state_r <= ST_DONE;
          end else if (limit_reached_s) begin
            // Re-load the same pattern to stop the detector's search.
            det_setar_palavra <= 1'b1;
            state_r           <= ST_CLEAR;
          end else begin
            state_r <= ST_SEARCH;
          end
        end
        ST_CLEAR: begin
          det_setar_palavra <= 1'b0;
          done              <= grant;
          hit               <= '0;
          state_r           <= ST_DONE;
        end
        ST_DONE: begin
          done     <= '0;
          hit      <= '0;
          grant    <= '0;
          busy     <= 1'b0;
          rr_ptr_r <= next_rr_s;
          state_r  <= ST_IDLE;
        end
        default: begin
          grant             <= '0;
          done              <= '0;
          hit               <= '0;
          busy              <= 1'b0;
          det_setar_palavra <= 1'b0;
          det_start         <= 1'b0;
          state_r           <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef SEQ_SCHED_STATS_EN
  // Saturating job-result counters, stepped once in each DONE state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count  <= 16'h0000;
      miss_count <= 16'h0000;
    end else if (state_r == ST_DONE) begin
      if (|hit) begin
        if (hit_count != 16'hFFFF) begin
          hit_count <= hit_count + 16'h0001;
        end else begin
          hit_count <= hit_count;
        end
      end else begin
        if (miss_count != 16'hFFFF) begin
          miss_count <= miss_count + 16'h0001;
        end else begin
          miss_count <= miss_count;
        end
      end
    end else begin
      hit_count  <= hit_count;
      miss_count <= miss_count;
    end
  end
`endif

endmodule

// File: tb/tb_sequencia_scheduler.sv
// -----------------------------------------------------------------------------
// Self-checking bench for sequencia_scheduler: a table of job vectors with
// hand-computed grant / pattern / search length / result, followed by
// hand-written sequences for asynchronous reset mid-search and round-robin
// fairness with requests held. Stats outputs are checked when
// SEQ_SCHED_STATS_EN is defined.
// -----------------------------------------------------------------------------
module tb_sequencia_scheduler;

  localparam int N_REQ   = 4;
  localparam int LIMIT_W = 8;
  localparam logic [31:0] PAL = 32'h813CFFA5; // req3=81 req2=3C req1=FF req0=A5

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] req_palavra;
  logic [7:0]  limite;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic [3:0]  hit;
  logic        busy;
  logic        det_setar_palavra;
  logic [7:0]  det_palavra;
  logic        det_start;
  logic        det_encontrado;
`ifdef SEQ_SCHED_STATS_EN
  logic [15:0] hit_count;
  logic [15:0] miss_count;
`endif

  int checks = 0;
  int errors = 0;

  sequencia_scheduler #(.N_REQ(N_REQ), .LIMIT_W(LIMIT_W)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .req               (req),
    .req_palavra       (req_palavra),
    .limite            (limite),
    .grant             (grant),
    .done              (done),
    .hit               (hit),
    .busy              (busy),
`ifdef SEQ_SCHED_STATS_EN
    .hit_count         (hit_count),
    .miss_count        (miss_count),
`endif
    .det_setar_palavra (det_setar_palavra),
    .det_palavra       (det_palavra),
    .det_start         (det_start),
    .det_encontrado    (det_encontrado)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [7:0] limite;
    int         found_at;   // SEARCH cycle (1-based) with encontrado high, 0 = never
    logic [3:0] exp_grant;
    logic [7:0] exp_pal;
    int         exp_len;    // number of SEARCH cycles
    logic       exp_hit;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int scount;
    @(negedge clk);
    req            = v.req;
    limite         = v.limite;
    det_encontrado = 1'b0;
    @(posedge clk); #1; // LOAD
    chk($sformatf("v%0d_grant", id), grant, v.exp_grant);
    chk($sformatf("v%0d_load_setar", id), det_setar_palavra, 1);
    chk($sformatf("v%0d_load_pal", id), det_palavra, v.exp_pal);
    chk($sformatf("v%0d_busy", id), busy, 1);
    req_palavra = ~PAL; // must be ignored after grant
    @(posedge clk); #1; // START
    chk($sformatf("v%0d_start", id), det_start, 1);
    chk($sformatf("v%0d_start_setar", id), det_setar_palavra, 0);
    @(posedge clk); #1; // first SEARCH cycle
    scount = 0;
    while (busy && !det_setar_palavra && !det_start && (done == 4'b0000) && (scount < 400)) begin
      scount++;
      det_encontrado = (scount == v.found_at);
      @(posedge clk); #1;
    end
    det_encontrado = 1'b0;
    chk($sformatf("v%0d_search_len", id), scount, v.exp_len);
    if (!v.exp_hit) begin
      chk($sformatf("v%0d_clear_setar", id), det_setar_palavra, 1);
      chk($sformatf("v%0d_clear_pal", id), det_palavra, v.exp_pal);
      chk($sformatf("v%0d_clear_done", id), done, 0);
      @(posedge clk); #1;
    end
    chk($sformatf("v%0d_done", id), done, v.exp_grant);
    chk($sformatf("v%0d_hit", id), hit, v.exp_hit ? v.exp_grant : 4'b0000);
    req         = 4'b0000;
    req_palavra = PAL;
    @(posedge clk); #1; // IDLE
    chk($sformatf("v%0d_idle_grant", id), grant, 0);
    chk($sformatf("v%0d_idle_done", id), done, 0);
    chk($sformatf("v%0d_idle_busy", id), busy, 0);
  endtask

  initial begin
    logic [3:0] rr_exp[4];
    int         waitc;
    int         done_seen;

    // rr pointer carries from one vector to the next.
    vecs[0] = '{req: 4'b0001, limite: 8'd20,  found_at: 3,  exp_grant: 4'b0001, exp_pal: 8'hA5, exp_len: 3,   exp_hit: 1'b1};
    vecs[1] = '{req: 4'b0010, limite: 8'd10,  found_at: 0,  exp_grant: 4'b0010, exp_pal: 8'hFF, exp_len: 10,  exp_hit: 1'b0};
    vecs[2] = '{req: 4'b0101, limite: 8'd5,   found_at: 5,  exp_grant: 4'b0100, exp_pal: 8'h3C, exp_len: 5,   exp_hit: 1'b1};
    vecs[3] = '{req: 4'b0101, limite: 8'd0,   found_at: 40, exp_grant: 4'b0001, exp_pal: 8'hA5, exp_len: 40,  exp_hit: 1'b1};
    vecs[4] = '{req: 4'b1001, limite: 8'd1,   found_at: 0,  exp_grant: 4'b1000, exp_pal: 8'h81, exp_len: 1,   exp_hit: 1'b0};
    vecs[5] = '{req: 4'b1111, limite: 8'd2,   found_at: 3,  exp_grant: 4'b0001, exp_pal: 8'hA5, exp_len: 2,   exp_hit: 1'b0};
    vecs[6] = '{req: 4'b1100, limite: 8'd3,   found_at: 1,  exp_grant: 4'b0100, exp_pal: 8'h3C, exp_len: 1,   exp_hit: 1'b1};
    vecs[7] = '{req: 4'b0110, limite: 8'd255, found_at: 0,  exp_grant: 4'b0010, exp_pal: 8'hFF, exp_len: 255, exp_hit: 1'b0};

    rst_n          = 1'b0;
    req            = 4'b0000;
    req_palavra    = PAL;
    limite         = 8'd0;
    det_encontrado = 1'b0;
    #2;
    chk("rst_grant", grant, 0);
    chk("rst_done", done, 0);
    chk("rst_hit", hit, 0);
    chk("rst_busy", busy, 0);
    chk("rst_setar", det_setar_palavra, 0);
    chk("rst_start", det_start, 0);
    chk("rst_pal", det_palavra, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i], i);
    end

`ifdef SEQ_SCHED_STATS_EN
    chk("stats_hits", hit_count, 4);
    chk("stats_misses", miss_count, 4);
`endif

    // Asynchronous reset in the middle of a SEARCH.
    @(negedge clk);
    req    = 4'b0001;
    limite = 8'd0;
    repeat (5) @(posedge clk);
    #3;
    chk("abort_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_grant", grant, 0);
    chk("abort_done", done, 0);
    chk("abort_start", det_start, 0);
    chk("abort_busy", busy, 0);
    req = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (done != 4'b0000) done_seen++;
    end
    chk("abort_no_done", done_seen, 0);
`ifdef SEQ_SCHED_STATS_EN
    chk("stats_rst_hits", hit_count, 0);
    chk("stats_rst_misses", miss_count, 0);
`endif

    // Round-robin with req held; every job misses on limite=2. rr starts at 0.
    rr_exp[0] = 4'b0001;
    rr_exp[1] = 4'b0010;
    rr_exp[2] = 4'b1000;
    rr_exp[3] = 4'b0001;
    @(negedge clk);
    limite = 8'd2;
    req    = 4'b1011;
    for (int j = 0; j < 4; j++) begin
      waitc = 0;
      @(posedge clk); #1;
      while ((grant == 4'b0000) && (waitc < 20)) begin
        waitc++;
        @(posedge clk); #1;
      end
      chk($sformatf("rr%0d_grant", j), grant, rr_exp[j]);
      waitc = 0;
      while ((done == 4'b0000) && (waitc < 20)) begin
        waitc++;
        @(posedge clk); #1;
      end
      chk($sformatf("rr%0d_done", j), done, rr_exp[j]);
      chk($sformatf("rr%0d_hit", j), hit, 0);
      if (j == 3) req = 4'b0000;
    end
    @(posedge clk); #1;
    chk("rr_final_idle", busy, 0);
`ifdef SEQ_SCHED_STATS_EN
    chk("stats_rr_hits", hit_count, 0);
    chk("stats_rr_misses", miss_count, 4);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
